// File: rtl/rr_priority_select.sv
// Combinational round-robin picker: returns the first requester above i_last,
// wrapping modulo PORTS, so the previously served index ends up lowest priority.
module rr_priority_select #(
    parameter int PORTS     = 2,
    parameter int SEL_WIDTH = 1
) (
    input  logic [PORTS-1:0]     i_req,
    input  logic [SEL_WIDTH-1:0] i_last,
    output logic [SEL_WIDTH-1:0] o_sel,
    output logic                 o_valid
);

    always_comb begin
        logic [SEL_WIDTH-1:0] w_idx;
        o_sel   = '0;
        o_valid = 1'b0;
        w_idx   = '0;
        // Offset PORTS lands back on i_last itself, so it is only chosen when alone.
        for (int k = 1; k <= PORTS; k++) begin
            w_idx = SEL_WIDTH'((int'(i_last) + k) % PORTS);
            if (!o_valid && i_req[w_idx]) begin
                o_valid = 1'b1;
                o_sel   = w_idx;
            end
        end
    end

endmodule

// File: rtl/udp_tx_arbiter.sv
// Frame-level round-robin arbiter sharing one UDP TX header/payload path between
// PORTS sources, with a completed-frame counter and a payload-stall watchdog.
module udp_tx_arbiter #(
    parameter int PORTS         = 2,
    parameter int DATA_WIDTH    = 8,
    parameter int STALL_TIMEOUT = 1250000,
    parameter int SEL_WIDTH     = (PORTS > 1) ? $clog2(PORTS) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [PORTS-1:0]            s_udp_hdr_valid,
    output logic [PORTS-1:0]            s_udp_hdr_ready,
    input  logic [32*PORTS-1:0]         s_ip_dest_ip,
    input  logic [16*PORTS-1:0]         s_udp_source_port,
    input  logic [16*PORTS-1:0]         s_udp_dest_port,
    input  logic [16*PORTS-1:0]         s_udp_length,
    input  logic [DATA_WIDTH*PORTS-1:0] s_udp_payload_axis_tdata,
    input  logic [PORTS-1:0]            s_udp_payload_axis_tvalid,
    output logic [PORTS-1:0]            s_udp_payload_axis_tready,
    input  logic [PORTS-1:0]            s_udp_payload_axis_tlast,
    input  logic [PORTS-1:0]            s_udp_payload_axis_tuser,
    output logic                        m_udp_hdr_valid,
    input  logic                        m_udp_hdr_ready,
    output logic [31:0]                 m_ip_dest_ip,
    output logic [15:0]                 m_udp_source_port,
    output logic [15:0]                 m_udp_dest_port,
    output logic [15:0]                 m_udp_length,
    output logic [DATA_WIDTH-1:0]       m_udp_payload_axis_tdata,
    output logic                        m_udp_payload_axis_tvalid,
    input  logic                        m_udp_payload_axis_tready,
    output logic                        m_udp_payload_axis_tlast,
    output logic                        m_udp_payload_axis_tuser,
    output logic [SEL_WIDTH-1:0]        grant_sel,
    output logic                        busy,
    output logic                        frame_done,
    output logic [15:0]                 frame_count,
    output logic                        stall
);

    localparam int CNT_W = (STALL_TIMEOUT > 1) ? $clog2(STALL_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] STALL_LAST = CNT_W'(STALL_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HDR     = 2'd1,
        PAYLOAD = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [SEL_WIDTH-1:0] r_grant_sel;
    logic [15:0]          r_frame_count;
    logic [CNT_W-1:0]     r_stall_cnt;
    logic [SEL_WIDTH-1:0] w_sel;
    logic                 w_sel_valid;
    logic                 w_beat;
    logic                 w_last_beat;

    rr_priority_select #(
        .PORTS     (PORTS),
        .SEL_WIDTH (SEL_WIDTH)
    ) u_select (
        .i_req   (s_udp_hdr_valid),
        .i_last  (r_grant_sel),
        .o_sel   (w_sel),
        .o_valid (w_sel_valid)
    );

    // Header and payload fields follow the grant with no register stage.
    assign m_ip_dest_ip             = s_ip_dest_ip[32*r_grant_sel +: 32];
    assign m_udp_source_port        = s_udp_source_port[16*r_grant_sel +: 16];
    assign m_udp_dest_port          = s_udp_dest_port[16*r_grant_sel +: 16];
    assign m_udp_length             = s_udp_length[16*r_grant_sel +: 16];
    assign m_udp_payload_axis_tdata = s_udp_payload_axis_tdata[DATA_WIDTH*r_grant_sel +: DATA_WIDTH];
    assign m_udp_payload_axis_tlast = s_udp_payload_axis_tlast[r_grant_sel];
    assign m_udp_payload_axis_tuser = s_udp_payload_axis_tuser[r_grant_sel];
    assign grant_sel                = r_grant_sel;
    assign busy                     = (r_state != IDLE);
    assign frame_count              = r_frame_count;

    always_comb begin
        w_next_state              = r_state;
        s_udp_hdr_ready           = '0;
        s_udp_payload_axis_tready = '0;
        m_udp_hdr_valid           = 1'b0;
        m_udp_payload_axis_tvalid = 1'b0;
        w_beat                    = 1'b0;
        w_last_beat               = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_sel_valid) w_next_state = HDR;
            end
            HDR: begin
                m_udp_hdr_valid              = s_udp_hdr_valid[r_grant_sel];
                s_udp_hdr_ready[r_grant_sel] = m_udp_hdr_ready;
                if (m_udp_hdr_valid && m_udp_hdr_ready) w_next_state = PAYLOAD;
            end
            PAYLOAD: begin
                m_udp_payload_axis_tvalid              = s_udp_payload_axis_tvalid[r_grant_sel];
                s_udp_payload_axis_tready[r_grant_sel] = m_udp_payload_axis_tready;
                w_beat      = m_udp_payload_axis_tvalid && m_udp_payload_axis_tready;
                w_last_beat = w_beat && m_udp_payload_axis_tlast;
                if (w_last_beat) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
        // Reset must silence every handshake in the very cycle it is asserted.
        if (rst) begin
            w_next_state              = IDLE;
            s_udp_hdr_ready           = '0;
            s_udp_payload_axis_tready = '0;
            m_udp_hdr_valid           = 1'b0;
            m_udp_payload_axis_tvalid = 1'b0;
            w_beat                    = 1'b0;
            w_last_beat               = 1'b0;
        end
        frame_done = w_last_beat;
        stall      = !rst && (r_state == PAYLOAD) && !w_beat && (r_stall_cnt == STALL_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_grant_sel   <= SEL_WIDTH'(PORTS - 1);
            r_frame_count <= 16'd0;
            r_stall_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == IDLE && w_sel_valid) r_grant_sel <= w_sel;
            if (w_last_beat) r_frame_count <= r_frame_count + 16'd1;
            // Stall only flags; the grant is kept so a frame is never truncated.
            if (r_state == PAYLOAD && !w_beat)
                r_stall_cnt <= (r_stall_cnt == STALL_LAST) ? '0 : r_stall_cnt + 1'b1;
            else
                r_stall_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Directed bench for udp_tx_arbiter: two modelled UDP sources plus a controllable sink,
// one task per scenario with inline checks against hand-computed values.
module tb_udp_tx_arbiter;

    localparam int PORTS = 2;
    localparam int DW    = 8;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [PORTS-1:0]      s_udp_hdr_valid = '0;
    logic [PORTS-1:0]      s_udp_hdr_ready;
    logic [32*PORTS-1:0]   s_ip_dest_ip = '0;
    logic [16*PORTS-1:0]   s_udp_source_port = '0;
    logic [16*PORTS-1:0]   s_udp_dest_port = '0;
    logic [16*PORTS-1:0]   s_udp_length = '0;
    logic [DW*PORTS-1:0]   s_udp_payload_axis_tdata = '0;
    logic [PORTS-1:0]      s_udp_payload_axis_tvalid = '0;
    logic [PORTS-1:0]      s_udp_payload_axis_tready;
    logic [PORTS-1:0]      s_udp_payload_axis_tlast = '0;
    logic [PORTS-1:0]      s_udp_payload_axis_tuser = '0;
    logic                  m_udp_hdr_valid;
    logic                  m_udp_hdr_ready = 1'b0;
    logic [31:0]           m_ip_dest_ip;
    logic [15:0]           m_udp_source_port;
    logic [15:0]           m_udp_dest_port;
    logic [15:0]           m_udp_length;
    logic [DW-1:0]         m_udp_payload_axis_tdata;
    logic                  m_udp_payload_axis_tvalid;
    logic                  m_udp_payload_axis_tready = 1'b0;
    logic                  m_udp_payload_axis_tlast;
    logic                  m_udp_payload_axis_tuser;
    logic [0:0]            grant_sel;
    logic                  busy;
    logic                  frame_done;
    logic [15:0]           frame_count;
    logic                  stall;

    udp_tx_arbiter #(
        .PORTS         (PORTS),
        .DATA_WIDTH    (DW),
        .STALL_TIMEOUT (16)
    ) dut (
        .clk                       (clk),
        .rst                       (rst),
        .s_udp_hdr_valid           (s_udp_hdr_valid),
        .s_udp_hdr_ready           (s_udp_hdr_ready),
        .s_ip_dest_ip              (s_ip_dest_ip),
        .s_udp_source_port         (s_udp_source_port),
        .s_udp_dest_port           (s_udp_dest_port),
        .s_udp_length              (s_udp_length),
        .s_udp_payload_axis_tdata  (s_udp_payload_axis_tdata),
        .s_udp_payload_axis_tvalid (s_udp_payload_axis_tvalid),
        .s_udp_payload_axis_tready (s_udp_payload_axis_tready),
        .s_udp_payload_axis_tlast  (s_udp_payload_axis_tlast),
        .s_udp_payload_axis_tuser  (s_udp_payload_axis_tuser),
        .m_udp_hdr_valid           (m_udp_hdr_valid),
        .m_udp_hdr_ready           (m_udp_hdr_ready),
        .m_ip_dest_ip              (m_ip_dest_ip),
        .m_udp_source_port         (m_udp_source_port),
        .m_udp_dest_port           (m_udp_dest_port),
        .m_udp_length              (m_udp_length),
        .m_udp_payload_axis_tdata  (m_udp_payload_axis_tdata),
        .m_udp_payload_axis_tvalid (m_udp_payload_axis_tvalid),
        .m_udp_payload_axis_tready (m_udp_payload_axis_tready),
        .m_udp_payload_axis_tlast  (m_udp_payload_axis_tlast),
        .m_udp_payload_axis_tuser  (m_udp_payload_axis_tuser),
        .grant_sel                 (grant_sel),
        .busy                      (busy),
        .frame_done                (frame_done),
        .frame_count               (frame_count),
        .stall                     (stall)
    );

    always #4 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Source model state: pending header, remaining bytes, extra frames to re-arm.
    logic [PORTS-1:0] hdrPend  = '0;
    logic [PORTS-1:0] payHold  = '0;
    int               bytesLeft[PORTS];
    int               bytesSent[PORTS];
    int               framesLeft[PORTS];
    int               frameLen[PORTS];
    logic [31:0]      cfgIp[PORTS];
    logic [15:0]      cfgSrc[PORTS];
    logic [15:0]      cfgDst[PORTS];
    logic [15:0]      cfgLen[PORTS];
    logic             rstReq  = 1'b1;
    logic             mHdrRdy = 1'b0;
    logic             mPayRdy = 1'b0;

    int               hdrLog[$];
    logic [7:0]       dataLog[$];
    logic             userLog[$];
    int               doneCnt = 0;

    task automatic clear_logs();
        hdrLog.delete();
        dataLog.delete();
        userLog.delete();
        doneCnt = 0;
    endtask

    task automatic reset_sources();
        for (int p = 0; p < PORTS; p++) begin
            bytesLeft[p]  = 0;
            bytesSent[p]  = 0;
            framesLeft[p] = 0;
        end
        hdrPend = '0;
        payHold = '0;
    endtask

    // One clock: drive after the rising edge, observe and advance the sources at the falling edge.
    task automatic step();
        @(posedge clk);
        #1;
        rst                       = rstReq;
        m_udp_hdr_ready           = mHdrRdy;
        m_udp_payload_axis_tready = mPayRdy;
        for (int p = 0; p < PORTS; p++) begin
            s_udp_hdr_valid[p]               = hdrPend[p];
            s_ip_dest_ip[32*p +: 32]         = cfgIp[p];
            s_udp_source_port[16*p +: 16]    = cfgSrc[p];
            s_udp_dest_port[16*p +: 16]      = cfgDst[p];
            s_udp_length[16*p +: 16]         = cfgLen[p];
            s_udp_payload_axis_tvalid[p]     = !hdrPend[p] && (bytesLeft[p] > 0) && !payHold[p];
            s_udp_payload_axis_tdata[DW*p +: DW] = 8'(64*p + bytesSent[p] + 1);
            s_udp_payload_axis_tlast[p]      = (bytesLeft[p] == 1);
            s_udp_payload_axis_tuser[p]      = (p == 0) && (bytesLeft[p] == 1);
        end
        @(negedge clk);
        if (m_udp_hdr_valid && m_udp_hdr_ready) hdrLog.push_back(int'(m_udp_source_port));
        if (m_udp_payload_axis_tvalid && m_udp_payload_axis_tready) begin
            dataLog.push_back(m_udp_payload_axis_tdata);
            userLog.push_back(m_udp_payload_axis_tuser);
        end
        if (frame_done) doneCnt++;
        for (int p = 0; p < PORTS; p++) begin
            if (s_udp_hdr_valid[p] && s_udp_hdr_ready[p]) hdrPend[p] = 1'b0;
            if (s_udp_payload_axis_tvalid[p] && s_udp_payload_axis_tready[p]) begin
                bytesLeft[p]--;
                bytesSent[p]++;
                if (bytesLeft[p] == 0 && framesLeft[p] > 0) begin
                    framesLeft[p]--;
                    hdrPend[p]   = 1'b1;
                    bytesLeft[p] = frameLen[p];
                    bytesSent[p] = 0;
                end
            end
        end
    endtask

    task automatic test_reset();
        rstReq = 1'b1;
        step();
        step();
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
        total++; if (grant_sel !== 1'b1) begin bad++; $display("[TB] FAIL reset_grant got=%0d exp=1", grant_sel); end
        total++; if (frame_count !== 16'd0) begin bad++; $display("[TB] FAIL reset_count got=%0d exp=0", frame_count); end
        total++; if (m_udp_hdr_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_hdr_valid got=%b exp=0", m_udp_hdr_valid); end
        total++; if (m_udp_payload_axis_tvalid !== 1'b0) begin bad++; $display("[TB] FAIL reset_tvalid got=%b exp=0", m_udp_payload_axis_tvalid); end
        total++; if (frame_done !== 1'b0 || stall !== 1'b0) begin bad++; $display("[TB] FAIL reset_pulses got=%b%b exp=00", frame_done, stall); end
        rstReq = 1'b0;
        step();
        total++; if (s_udp_hdr_ready !== 2'b00 || s_udp_payload_axis_tready !== 2'b00) begin
            bad++; $display("[TB] FAIL idle_readies got=%b/%b exp=00/00", s_udp_hdr_ready, s_udp_payload_axis_tready);
        end
    endtask

    task automatic test_single();
        clear_logs();
        mHdrRdy = 1'b1;
        mPayRdy = 1'b1;
        hdrPend[0] = 1'b1;
        bytesLeft[0] = 4;
        bytesSent[0] = 0;
        step();
        total++; if (m_udp_hdr_valid !== 1'b0) begin bad++; $display("[TB] FAIL single_decide_cycle got=%b exp=0", m_udp_hdr_valid); end
        step();
        total++; if (m_udp_hdr_valid !== 1'b1) begin bad++; $display("[TB] FAIL single_hdr_valid got=%b exp=1", m_udp_hdr_valid); end
        total++; if (m_ip_dest_ip !== 32'hC0A80180) begin bad++; $display("[TB] FAIL single_ip got=%h exp=c0a80180", m_ip_dest_ip); end
        total++; if (m_udp_source_port !== 16'd1234 || m_udp_dest_port !== 16'd5678) begin
            bad++; $display("[TB] FAIL single_ports got=%0d/%0d exp=1234/5678", m_udp_source_port, m_udp_dest_port);
        end
        total++; if (m_udp_length !== 16'd12) begin bad++; $display("[TB] FAIL single_len got=%0d exp=12", m_udp_length); end
        for (int c = 0; c < 20 && bytesLeft[0] > 0; c++) step();
        step();
        total++; if (dataLog.size() !== 4) begin bad++; $display("[TB] FAIL single_beats got=%0d exp=4", dataLog.size()); end
        for (int i = 0; i < 4 && i < dataLog.size(); i++) begin
            total++; if (dataLog[i] !== 8'(i + 1)) begin bad++; $display("[TB] FAIL single_byte%0d got=%h exp=%h", i, dataLog[i], 8'(i + 1)); end
        end
        total++; if (userLog.size() != 4 || userLog[3] !== 1'b1 || userLog[0] !== 1'b0) begin
            bad++; $display("[TB] FAIL single_tuser got_n=%0d exp=0001", userLog.size());
        end
        total++; if (doneCnt !== 1) begin bad++; $display("[TB] FAIL single_done got=%0d exp=1", doneCnt); end
        total++; if (frame_count !== 16'd1) begin bad++; $display("[TB] FAIL single_count got=%0d exp=1", frame_count); end
        total++; if (grant_sel !== 1'b0 || busy !== 1'b0) begin bad++; $display("[TB] FAIL single_end got=g%0d b%b exp=g0 b0", grant_sel, busy); end
    endtask

    task automatic test_round_robin();
        rstReq = 1'b1;
        step();
        rstReq = 1'b0;
        reset_sources();
        clear_logs();
        for (int p = 0; p < PORTS; p++) begin
            frameLen[p]   = 2;
            bytesLeft[p]  = 2;
            framesLeft[p] = 2;
        end
        hdrPend = 2'b11;
        for (int c = 0; c < 200 && !(hdrPend == 2'b00 && bytesLeft[0] == 0 && bytesLeft[1] == 0); c++) step();
        step();
        total++; if (hdrLog.size() !== 6) begin bad++; $display("[TB] FAIL rr_frames got=%0d exp=6", hdrLog.size()); end
        for (int i = 0; i < 6 && i < hdrLog.size(); i++) begin
            total++; if (hdrLog[i] !== int'(cfgSrc[i % 2])) begin
                bad++; $display("[TB] FAIL rr_order%0d got=%0d exp=%0d", i, hdrLog[i], cfgSrc[i % 2]);
            end
        end
        total++; if (frame_count !== 16'd6) begin bad++; $display("[TB] FAIL rr_count got=%0d exp=6", frame_count); end
        total++; if (dataLog.size() !== 12) begin bad++; $display("[TB] FAIL rr_bytes got=%0d exp=12", dataLog.size()); end
    endtask

    task automatic test_backpressure();
        int badTr;
        int badOther;
        badTr    = 0;
        badOther = 0;
        clear_logs();
        frameLen[0] = 8;
        bytesLeft[0] = 8;
        bytesSent[0] = 0;
        bytesLeft[1] = 1;
        bytesSent[1] = 0;
        hdrPend = 2'b11;
        for (int c = 0; c < 100 && bytesLeft[0] > 0; c++) begin
            mPayRdy = (c % 2 == 0);
            step();
            if (s_udp_payload_axis_tready[0] && !mPayRdy) badTr++;
            if (s_udp_payload_axis_tready[1] !== 1'b0) badOther++;
        end
        mPayRdy = 1'b1;
        total++; if (dataLog.size() !== 8) begin bad++; $display("[TB] FAIL bp_beats got=%0d exp=8", dataLog.size()); end
        for (int i = 0; i < 8 && i < dataLog.size(); i++) begin
            total++; if (dataLog[i] !== 8'(i + 1)) begin bad++; $display("[TB] FAIL bp_byte%0d got=%h exp=%h", i, dataLog[i], 8'(i + 1)); end
        end
        total++; if (badTr !== 0) begin bad++; $display("[TB] FAIL bp_ready_leak got=%0d exp=0", badTr); end
        total++; if (badOther !== 0) begin bad++; $display("[TB] FAIL bp_other_ready got=%0d exp=0", badOther); end
        for (int c = 0; c < 50 && !(hdrPend == 2'b00 && bytesLeft[1] == 0); c++) step();
        step();
        total++; if (dataLog.size() != 9 || dataLog[8] !== 8'h41) begin
            bad++; $display("[TB] FAIL bp_port1_after got_n=%0d exp_n=9 last=41", dataLog.size());
        end
    endtask

    task automatic test_header_hold();
        int holdBad;
        holdBad = 0;
        clear_logs();
        mHdrRdy = 1'b0;
        hdrPend[1] = 1'b1;
        bytesLeft[1] = 2;
        bytesSent[1] = 0;
        step();
        for (int c = 0; c < 20; c++) begin
            step();
            if (m_udp_hdr_valid !== 1'b1 || m_ip_dest_ip !== cfgIp[1] || m_udp_source_port !== cfgSrc[1] ||
                m_udp_dest_port !== cfgDst[1] || m_udp_length !== cfgLen[1] ||
                s_udp_payload_axis_tready !== 2'b00 || m_udp_payload_axis_tvalid !== 1'b0) holdBad++;
        end
        total++; if (holdBad !== 0) begin bad++; $display("[TB] FAIL hold_stable got=%0d exp=0", holdBad); end
        total++; if (hdrLog.size() !== 0) begin bad++; $display("[TB] FAIL hold_early_hs got=%0d exp=0", hdrLog.size()); end
        mHdrRdy = 1'b1;
        for (int c = 0; c < 20 && bytesLeft[1] > 0; c++) step();
        step();
        total++; if (hdrLog.size() != 1 || hdrLog[0] !== 4000) begin bad++; $display("[TB] FAIL hold_hdr got_n=%0d exp src=4000", hdrLog.size()); end
        total++; if (dataLog.size() != 2 || dataLog[0] !== 8'h41 || dataLog[1] !== 8'h42) begin
            bad++; $display("[TB] FAIL hold_data got_n=%0d exp=41,42", dataLog.size());
        end
        total++; if (frame_count !== 16'd9) begin bad++; $display("[TB] FAIL hold_count got=%0d exp=9", frame_count); end
    endtask

    task automatic test_watchdog();
        int stallHits;
        int firstStall;
        int secondStall;
        int grantBad;
        stallHits   = 0;
        firstStall  = 0;
        secondStall = 0;
        grantBad    = 0;
        clear_logs();
        hdrPend[0] = 1'b1;
        bytesLeft[0] = 5;
        bytesSent[0] = 0;
        for (int c = 0; c < 20 && bytesSent[0] < 2; c++) step();
        payHold[0] = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (stall === 1'b1) begin
                stallHits++;
                if (firstStall == 0) firstStall = i;
                else if (secondStall == 0) secondStall = i;
            end
            if (grant_sel !== 1'b0 || busy !== 1'b1) grantBad++;
        end
        payHold[0] = 1'b0;
        for (int c = 0; c < 20 && bytesLeft[0] > 0; c++) step();
        step();
        total++; if (stallHits !== 2) begin bad++; $display("[TB] FAIL wd_hits got=%0d exp=2", stallHits); end
        total++; if (firstStall !== 16 || secondStall !== 32) begin
            bad++; $display("[TB] FAIL wd_cycles got=%0d,%0d exp=16,32", firstStall, secondStall);
        end
        total++; if (grantBad !== 0) begin bad++; $display("[TB] FAIL wd_grant_kept got=%0d exp=0", grantBad); end
        total++; if (dataLog.size() != 5 || dataLog[4] !== 8'h05) begin bad++; $display("[TB] FAIL wd_data got_n=%0d exp=5", dataLog.size()); end
        total++; if (frame_count !== 16'd10) begin bad++; $display("[TB] FAIL wd_count got=%0d exp=10", frame_count); end
    endtask

    task automatic test_reset_mid();
        clear_logs();
        hdrPend[0] = 1'b1;
        bytesLeft[0] = 6;
        bytesSent[0] = 0;
        for (int c = 0; c < 20 && bytesSent[0] < 2; c++) step();
        rstReq = 1'b1;
        step();
        total++; if (s_udp_payload_axis_tready !== 2'b00 || m_udp_payload_axis_tvalid !== 1'b0) begin
            bad++; $display("[TB] FAIL rstmid_same_cycle got=%b/%b exp=00/0", s_udp_payload_axis_tready, m_udp_payload_axis_tvalid);
        end
        total++; if (dataLog.size() !== 2) begin bad++; $display("[TB] FAIL rstmid_no_byte3 got=%0d exp=2", dataLog.size()); end
        reset_sources();
        rstReq = 1'b0;
        step();
        total++; if (busy !== 1'b0 || grant_sel !== 1'b1 || frame_count !== 16'd0) begin
            bad++; $display("[TB] FAIL rstmid_state got=b%b g%0d c%0d exp=b0 g1 c0", busy, grant_sel, frame_count);
        end
        total++; if (m_udp_hdr_valid !== 1'b0 || s_udp_hdr_ready !== 2'b00) begin
            bad++; $display("[TB] FAIL rstmid_hdr got=%b/%b exp=0/00", m_udp_hdr_valid, s_udp_hdr_ready);
        end
        clear_logs();
        hdrPend = 2'b11;
        bytesLeft[0] = 1;
        bytesLeft[1] = 1;
        for (int c = 0; c < 50 && !(hdrPend == 2'b00 && bytesLeft[0] == 0 && bytesLeft[1] == 0); c++) step();
        step();
        total++; if (hdrLog.size() != 2 || hdrLog[0] !== 1234) begin
            bad++; $display("[TB] FAIL rstmid_first_port got_n=%0d exp first src=1234", hdrLog.size());
        end
    endtask

    initial begin
        cfgIp[0]  = 32'hC0A80180; cfgSrc[0] = 16'd1234; cfgDst[0] = 16'd5678; cfgLen[0] = 16'd12;
        cfgIp[1]  = 32'h0A000002; cfgSrc[1] = 16'd4000; cfgDst[1] = 16'd4001; cfgLen[1] = 16'd10;
        reset_sources();
        for (int p = 0; p < PORTS; p++) frameLen[p] = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_header_hold();
        test_watchdog();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
